// File: rtl/square_period_detector.sv
// Recovers the square-wave `period` word from a 24-bit sample stream by timing polarity half-cycles.
// Optional hysteresis on the polarity slicer is enabled with `define SQPD_HYSTERESIS_EN.
module square_period_detector #(
    parameter int unsigned LOCK_COUNT   = 2,
    parameter logic [23:0] HYST         = 24'h100000,
    parameter int unsigned CNT_SAT_LOG2 = 18
) (
    input  logic        clk48m,
    input  logic        rst_n,
    input  logic [23:0] sample,
    output logic [18:0] period,
    output logic        locked,
    output logic        period_update
);

    typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_t;

    localparam logic [18:0] CNT_SAT = 19'(1) << CNT_SAT_LOG2;
    localparam logic [2:0]  LOCK_N  = 3'(LOCK_COUNT);
    localparam logic signed [24:0] HYST_P = {1'b0, HYST};
    localparam logic signed [24:0] HYST_N = -HYST_P;
`ifdef SQPD_HYSTERESIS_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic [18:0] cnt_q, cnt_d;
    logic [17:0] cand_q, cand_d;
    logic [2:0]  match_q, match_d;
    logic [18:0] period_q, period_d;
    logic        locked_q, locked_d;
    logic        upd_q, upd_d;

    logic               level;
    logic               edge_det;
    logic               timeout;
    logic signed [24:0] samp_ext;

    assign samp_ext = {sample[23], sample};

    // Inside the hysteresis band the slicer holds its previous decision.
    always_comb begin
        level = ~sample[23];
        if (HYST_EN) begin
            level = s_q;
            if (samp_ext > HYST_P)      level = 1'b1;
            else if (samp_ext < HYST_N) level = 1'b0;
        end
    end

    assign edge_det = (level != s_q);
    assign timeout  = (state_q != IDLE) && (cnt_q == CNT_SAT);

    always_comb begin
        s_d      = level;
        cnt_d    = edge_det ? 19'd0 : ((cnt_q == CNT_SAT) ? cnt_q : cnt_q + 19'd1);
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        period_d = period_q;
        locked_d = locked_q;

        if (timeout) begin
            state_d  = edge_det ? ARMED : IDLE;
            locked_d = 1'b0;
            period_d = 19'd0;
            match_d  = 3'd0;
        end else if (edge_det) begin
            if (state_q == IDLE) begin
                state_d = ARMED;
                match_d = 3'd0;
            end else if (cnt_q == 19'd0) begin
                // Toggling every cycle is not a usable measurement.
                state_d  = ARMED;
                match_d  = 3'd0;
                locked_d = 1'b0;
            end else if (state_q != ARMED && cnt_q[17:0] == cand_q) begin
                if (state_q == TRACK) begin
                    if (match_q + 3'd1 >= LOCK_N) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        period_d = {cand_q, 1'b0};
                    end
                    match_d = match_q + 3'd1;
                end
            end else begin
                cand_d  = cnt_q[17:0];
                match_d = 3'd1;
                if (state_q == ARMED && LOCK_N == 3'd1) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                    period_d = {cnt_q[17:0], 1'b0};
                end else begin
                    state_d  = TRACK;
                    locked_d = 1'b0;
                end
            end
        end

        upd_d = (period_d != period_q);
    end

    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= 1'b0;
            cnt_q    <= 19'd0;
            cand_q   <= 18'd0;
            match_q  <= 3'd0;
            period_q <= 19'd0;
            locked_q <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            period_q <= period_d;
            locked_q <= locked_d;
            upd_q    <= upd_d;
        end
    end

    assign period        = period_q;
    assign locked        = locked_q;
    assign period_update = upd_q;

endmodule

// File: tb/tb_square_period_detector.sv
// Randomized bench for square_period_detector: a measurement-history model predicts period/locked,
// and a queue of expected period_update values is drained by a negedge monitor.
module tb_square_period_detector;

    localparam int     LOCK_COUNT = 2;
    localparam int     SAT_LOG2   = 13;
    localparam longint SAT        = longint'(1) << SAT_LOG2;

    logic        clk48m = 1'b0;
    logic        rst_n  = 1'b0;
    logic [23:0] sample = 24'd0;
    logic [18:0] period;
    logic        locked;
    logic        period_update;

    square_period_detector #(
        .LOCK_COUNT  (LOCK_COUNT),
        .HYST        (24'h100000),
        .CNT_SAT_LOG2(SAT_LOG2)
    ) dut (
        .clk48m       (clk48m),
        .rst_n        (rst_n),
        .sample       (sample),
        .period       (period),
        .locked       (locked),
        .period_update(period_update)
    );

    always #5 clk48m = ~clk48m;

    int          total = 0;
    int          bad   = 0;
    int          upd_seen = 0;
    bit          chk_en = 1'b0;
    bit          lvl_now = 1'b0;

    longint      cyc = 0;
    longint      base = 0;
    bit          active;
    bit          m_s;
    int          hist[$];
    logic [18:0] exp_period;
    bit          exp_locked;
    logic [18:0] upd_fifo[$];

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_s        = 1'b0;
        active     = 1'b0;
        hist.delete();
        exp_period = 19'd0;
        exp_locked = 1'b0;
        upd_fifo.delete();
        base       = cyc;
    endfunction

    function automatic bit model_level(logic [23:0] s);
`ifdef SQPD_HYSTERESIS_EN
        int v;
        v = $signed(s);
        if (v > 32'sh100000)  return 1'b1;
        if (v < -32'sh100000) return 1'b0;
        return m_s;
`else
        return !s[23];
`endif
    endfunction

    // Locked means: the last LOCK_COUNT half-cycle lengths since (re)start are equal and nonzero.
    function automatic void model_step(logic [23:0] s);
        bit          lvl;
        bit          e;
        longint      c;
        logic [18:0] new_p;
        bit          new_l;
        bit          eq;
        lvl   = model_level(s);
        e     = (lvl != m_s);
        c     = cyc - base;
        if (c > SAT) c = SAT;
        new_p = exp_period;
        new_l = exp_locked;
        if (active && c >= SAT) begin
            hist.delete();
            new_l  = 1'b0;
            new_p  = 19'd0;
            active = e;
        end else if (e) begin
            if (!active) begin
                active = 1'b1;
                hist.delete();
            end else if (c == 0) begin
                hist.delete();
                new_l = 1'b0;
            end else begin
                hist.push_back(int'(c));
                if (hist.size() > LOCK_COUNT) void'(hist.pop_front());
                eq = (hist.size() == LOCK_COUNT);
                foreach (hist[i]) if (hist[i] != hist[0]) eq = 1'b0;
                new_l = eq;
                if (eq) new_p = 19'(2 * c);
            end
        end
        if (new_p != exp_period) upd_fifo.push_back(new_p);
        exp_period = new_p;
        exp_locked = new_l;
        m_s        = lvl;
        if (e) base = cyc + 1;
        cyc++;
    endfunction

    function automatic logic [23:0] rand_sample(bit lvl);
        logic [22:0] mag;
        mag = 23'($urandom);
        return lvl ? {1'b0, mag} : {1'b1, mag};
    endfunction

    task automatic step(input logic [23:0] s);
        sample = s;
        @(posedge clk48m);
        model_step(s);
        #1;
    endtask

    task automatic hold(input bit lvl, input int n);
        repeat (n) step(rand_sample(lvl));
    endtask

    task automatic wave(input int p, input int halves);
        for (int i = 0; i < halves; i++) begin
            lvl_now = !lvl_now;
            hold(lvl_now, (p >> 1) + 1);
        end
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_period", period, 0);
        check("rst_locked", locked, 0);
        check("rst_update", period_update, 0);
        repeat (3) @(posedge clk48m);
        #1;
        rst_n   = 1'b1;
        lvl_now = 1'b0;
    endtask

    always @(negedge clk48m) begin
        if (chk_en) begin
            check("period", period, exp_period);
            check("locked", locked, exp_locked);
            check("update_strobe", period_update, upd_fifo.size() > 0);
            if (period_update) upd_seen++;
            if (upd_fifo.size() > 0) begin
                automatic logic [18:0] e = upd_fifo.pop_front();
                if (period_update) check("update_value", period, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        model_reset();
        repeat (3) @(posedge clk48m);
        #1;
        chk_en = 1'b1;
        check("init_period", period, 0);
        check("init_locked", locked, 0);
        rst_n = 1'b1;

        // P=1000: lock on the third edge, one update pulse
        u0 = upd_seen;
        wave(1000, 2);
        lvl_now = !lvl_now;
        step(rand_sample(lvl_now));
        check("p1000_locked_edge3", locked, 1);
        check("p1000_period", period, 1000);
        hold(lvl_now, 500 + 20);
        check("p1000_one_pulse", upd_seen - u0, 1);

        wave(1000, 2);
        wave(1001, 4);
        check("p1001_period", period, 1000);
        wave(2, 4);
        check("p2_period", period, 2);
        check("p2_locked", locked, 1);

        do_reset();
        wave(1, 20);
        check("p1_period", period, 0);
        check("p1_locked", locked, 0);

        // Lock then hold low until timeout
        do_reset();
        wave(1000, 3);
        check("to_pre_period", period, 1000);
        u0 = upd_seen;
        lvl_now = 1'b0;
        repeat (SAT + 10) step(24'h800000);
        check("to_period", period, 0);
        check("to_locked", locked, 0);
        check("to_one_pulse", upd_seen - u0, 1);

        // P=1000 -> P=2000
        wave(1000, 3);
        check("sw_pre_period", period, 1000);
        wave(2000, 1);
        lvl_now = !lvl_now;
        step(rand_sample(lvl_now));
        check("sw_unlocked", locked, 0);
        check("sw_period_held", period, 1000);
        u0 = upd_seen;
        hold(lvl_now, 1000);
        wave(2000, 2);
        check("sw_period", period, 2000);
        check("sw_locked", locked, 1);
        check("sw_one_pulse", upd_seen - u0, 1);

        // P=500 lock, reset mid-half, relock
        wave(500, 3);
        check("p500_period", period, 500);
        hold(lvl_now, 100);
        do_reset();
        wave(500, 3);
        check("p500_relock", period, 500);
        check("p500_relock_locked", locked, 1);

        // Small-amplitude toggling around zero
        do_reset();
        for (int i = 0; i < 6; i++) begin
            repeat (100) step((i % 2 == 0) ? 24'h000010 : 24'hFFFFF0);
        end
`ifdef SQPD_HYSTERESIS_EN
        check("small_period", period, 0);
`else
        check("small_period", period, 198);
`endif

        // Random periods
        do_reset();
        for (int k = 0; k < 8; k++) begin
            automatic int p = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 1200));
            wave(p, int'($urandom_range(2, 4)));
        end
        hold(lvl_now, 5);
        check("fifo_empty", upd_fifo.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/square_period_detector.md
Name: square_period_detector

Overview:
- Inverse of the square-wave synth voice: takes a 24-bit signed sample stream at clk48m and recovers the `period` word that produced it.
- Measures half-cycle length between polarity transitions. Reports a locked period only after repeated equal measurements.
- Sits on the analysis/loopback path, e.g. self-test of synth voices or pitch tracking of an incoming square tone.

Parameters:
- LOCK_COUNT, 2, consecutive equal half-period measurements required to lock (1..7).
- HYST, 24'h100000, hysteresis magnitude; used only with SQPD_HYSTERESIS_EN.

Ports:
- clk48m  input  1  system clock, 48 MHz, one sample per cycle.
- rst_n  input  1  asynchronous active-low reset.
- sample  input  24  two's-complement audio sample.
- period  output  19  recovered period; always even; 0 = no tone.
- locked  output  1  high while the `period` value is confirmed by the current signal.
- period_update  output  1  one-cycle strobe whenever `period` changes value.

Behaviour:
- Polarity: level = ~sample[23] (0x7fffff -> 1, 0x800000 -> 0). s_q is the registered level; edge = (level != s_q).
- cnt: 19-bit register. Cleared on every edge cycle, else cnt+1, saturating at 2^18. At an edge the measured half m = cnt (pre-clear value).
- Conversion: period = {m[17:0], 1'b0}.
  - Matches a generator with P: toggles every (P>>1)+1 cycles, so m = P>>1 and output = P & ~1.
- m == 0 (toggle every cycle): rejected. Clears the match count and keeps the current candidate invalid.
- States:
  - IDLE: no edge seen. Edge -> ARMED.
  - ARMED: one edge seen. Edge with m != 0 -> cand = m, match = 1 -> TRACK. If LOCK_COUNT == 1, go directly to LOCKED instead.
  - TRACK, on edge:
    - m == cand: match+1. When match reaches LOCK_COUNT -> LOCKED, locked = 1, period <= cand<<1.
    - m != cand: cand = m, match = 1.
  - LOCKED, on edge:
    - m == cand: no change.
    - m != cand: locked = 0, period held, cand = m, match = 1 -> TRACK.
- Timeout: cnt reaching 2^18 in ARMED, TRACK or LOCKED -> IDLE, locked = 0, period = 0.
  - Edge in the same cycle: timeout wins; next state is ARMED with cnt cleared instead of IDLE.
- period_update: asserted the cycle after a registered change of period (new lock value differing from the old one, or timeout clearing a nonzero period). Never asserted when the value is unchanged.
- Latency: locked/period update on the clock edge that samples the locking edge's sample, visible the following cycle. period_update is aligned with the new period value.
- Reset (rst_n low, async): period = 0, locked = 0, period_update = 0, state IDLE, cnt = 0, s_q = 0, match = 0, cand = 0.
  - Reset mid-lock drops all outputs immediately.
  - The first sample after reset with level 1 is treated as an edge (IDLE -> ARMED).

Optional Feature:
- Macro SQPD_HYSTERESIS_EN.
- Defined: level = 1 only when signed sample > +HYST; level = 0 only when sample < -HYST; otherwise level = s_q (no edge).
- Undefined: level = ~sample[23]. HYST is ignored.

Test Plan:
- Generator-equivalent wave P=1000 (toggle every 501 cycles, LOCK_COUNT=2) -> locked rises on the 3rd edge, period=1000, exactly one period_update pulse; no further pulses over 20 cycles.
- P=1001 -> period=1000. P=2 (toggle every 2 cycles) -> period=2. P=1 (toggle every cycle) -> never locks, period stays 0.
- Lock at P=1000, then hold sample=0x800000 -> 2^18 cycles after the last edge: period=0, locked=0, one period_update pulse.
- Lock at P=1000, switch to P=2000 -> locked falls at the first mismatched edge with period held at 1000. Relock after two equal measurements: period=2000, one update pulse.
- Lock at P=500, pulse rst_n low for 3 cycles mid-half-period -> outputs 0 asynchronously. After release, relock to 500 within 3 edges.
- Sample toggling 24'h000010/24'hFFFFF0 every 100 cycles -> with SQPD_HYSTERESIS_EN: no edges, period=0. Without: locks with period=198.
